// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and default widths for the cache-to-memory request arbiter.
//   mem_arb_state_t : transaction phase (idle, request issued, waiting for data)
//   mem_arb_owner_t : which cache owns the transaction in flight
package mem_req_arbiter_pkg;

  localparam int DEF_ADDR_W = 40;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } mem_arb_state_t;

  typedef enum logic {
    ARB_OWNER_IC,
    ARB_OWNER_DC
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Memory-side request/response port shared by the caches.
//   req_valid / req_ready : request handshake (master drives valid)
//   req_we, req_addr, req_wdata : request payload, stable while req_valid
//   resp_valid, resp_data : single-cycle response from memory
// Modports: master = arbiter side, slave = memory side.
interface mem_req_arbiter_if
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the single memory request port between icache refills and dcache line
// transactions. Round-robin between the two caches, one transaction in flight,
// registered response routed back to the owning cache. An icache refill killed by
// a fetch redirect still completes on the memory side, but its data is dropped.
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   ic_req_*/ic_kill_i     icache refill request, ready, kill of outstanding refill
//   ic_resp_*              icache refill data, valid pulses for one cycle
//   dc_req_*               dcache refill/writeback request and ready
//   dc_resp_*              dcache response, pulses for writes as well
//   mem                    memory request/response port (master side)
//   busy_o                 transaction in flight
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,

  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  input  logic              ic_kill_i,
  output logic              ic_resp_valid_o,
  output logic [LINE_W-1:0] ic_resp_data_o,

  input  logic              dc_req_valid_i,
  input  logic              dc_req_we_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_wdata_i,
  output logic              dc_req_ready_o,
  output logic              dc_resp_valid_o,
  output logic [LINE_W-1:0] dc_resp_data_o,

  mem_req_arbiter_if.master mem,

  output logic              busy_o
);

  mem_arb_state_t state_q, state_d;
  mem_arb_owner_t last_grant_q;
  mem_arb_owner_t owner_q;
  logic           kill_q;

  logic              cap_we_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [LINE_W-1:0] cap_wdata_q;

  logic              ic_resp_valid_q;
  logic              dc_resp_valid_q;
  logic [LINE_W-1:0] ic_resp_data_q;
  logic [LINE_W-1:0] dc_resp_data_q;

  logic gnt_ic;
  logic gnt_dc;
  logic accept;
  logic kill_now;
  logic resp_done;
  logic deliver_ic;
  logic deliver_dc;

  // Grant: a lone requester wins; on a tie the side that did not win last time wins.
  always_comb begin
    gnt_dc = dc_req_valid_i && (!ic_req_valid_i || (last_grant_q == ARB_OWNER_IC));
    gnt_ic = ic_req_valid_i && !gnt_dc;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_ic || gnt_dc) begin
          state_d = ARB_ISSUE;
          accept  = 1'b1;
        end
      end
      ARB_ISSUE: begin
        if (mem.req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem.resp_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A kill arriving in the same cycle as the response must still suppress it,
  // so the live input is ORed with the sticky flag.
  always_comb begin
    kill_now   = ic_kill_i && (owner_q == ARB_OWNER_IC) && (state_q != ARB_IDLE);
    resp_done  = (state_q == ARB_WAIT) && mem.resp_valid;
    deliver_ic = resp_done && (owner_q == ARB_OWNER_IC) && !kill_q && !ic_kill_i;
    deliver_dc = resp_done && (owner_q == ARB_OWNER_DC);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= ARB_IDLE;
      last_grant_q    <= ARB_OWNER_IC;
      owner_q         <= ARB_OWNER_IC;
      kill_q          <= 1'b0;
      cap_we_q        <= 1'b0;
      cap_addr_q      <= '0;
      cap_wdata_q     <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= '0;
      dc_resp_data_q  <= '0;
    end else begin
      state_q <= state_d;

      // Capture stage: request payload frozen at accept, held until memory takes it.
      if (accept) begin
        owner_q      <= gnt_dc ? ARB_OWNER_DC : ARB_OWNER_IC;
        last_grant_q <= gnt_dc ? ARB_OWNER_DC : ARB_OWNER_IC;
        cap_we_q     <= gnt_dc && dc_req_we_i;
        cap_addr_q   <= gnt_dc ? dc_req_addr_i : ic_req_addr_i;
        cap_wdata_q  <= gnt_dc ? dc_req_wdata_i : '0;
      end

      if (state_d == ARB_IDLE) kill_q <= 1'b0;
      else if (kill_now)       kill_q <= 1'b1;

      // Response stage: one-cycle pulse to the owner; data held between pulses.
      ic_resp_valid_q <= deliver_ic;
      dc_resp_valid_q <= deliver_dc;
      if (deliver_ic) ic_resp_data_q <= mem.resp_data;
      if (deliver_dc) dc_resp_data_q <= mem.resp_data;
    end
  end

  assign ic_req_ready_o  = rstn_i && (state_q == ARB_IDLE) && gnt_ic;
  assign dc_req_ready_o  = rstn_i && (state_q == ARB_IDLE) && gnt_dc;

  assign mem.req_valid   = (state_q == ARB_ISSUE);
  assign mem.req_we      = cap_we_q;
  assign mem.req_addr    = cap_addr_q;
  assign mem.req_wdata   = cap_wdata_q;

  assign ic_resp_valid_o = ic_resp_valid_q;
  assign ic_resp_data_o  = ic_resp_data_q;
  assign dc_resp_valid_o = dc_resp_valid_q;
  assign dc_resp_data_o  = dc_resp_data_q;

  assign busy_o          = (state_q != ARB_IDLE);

`ifndef SYNTHESIS
  // Memory must only answer while a request is outstanding.
  a_resp_only_in_wait: assert property (
    @(posedge clk_i) disable iff (!rstn_i) mem.resp_valid |-> (state_q == ARB_WAIT)
  );
`endif

endmodule
